// File: rtl/taxel_uart_pkg.sv
// Shared types and constants for the taxel frame scheduler.
// The optional checksum word is enabled by defining TAXEL_CHECKSUM_EN.
package taxel_uart_pkg;

  localparam int SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] DEFAULT_HEADER_WORD = 12'hA5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_CSUM,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/frame_checksum.sv
// 12-bit wrapping sample accumulator; instantiated by the scheduler only
// when TAXEL_CHECKSUM_EN is defined.
module frame_checksum
  import taxel_uart_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                add_en,
  input  logic [SAMPLE_W-1:0] add_data,
  output logic [SAMPLE_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule

// File: rtl/taxel_uart_scheduler.sv
// Reads one frame of taxel samples and feeds them to uart_transmit behind a
// sync header; TAXEL_CHECKSUM_EN appends a 12-bit checksum word per frame.
module taxel_uart_scheduler
  import taxel_uart_pkg::*;
#(
  parameter int                  NUM_TAXELS  = 64,
  parameter logic [SAMPLE_W-1:0] HEADER_WORD = DEFAULT_HEADER_WORD,
  localparam int                 ADDR_W      = (NUM_TAXELS > 1) ? $clog2(NUM_TAXELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                frame_ready_in,
  input  logic                transmit_active_in,
  output logic [ADDR_W-1:0]   rd_addr_out,
  input  logic [SAMPLE_W-1:0] rd_data_in,
  input  logic                uart_ready_in,
  output logic [SAMPLE_W-1:0] uart_data_out,
  output logic                uart_valid_out,
  output logic                busy_out,
  output logic                frame_done_out,
  output logic                overrun_out
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAXELS - 1);

  sched_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   idx_d;
  logic [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0] data_d;
  logic                valid_d, done_d, overrun_d, busy_d;
  logic                pending_q, pending_d;
  logic                guard_q;
  logic                start, permit;

`ifdef TAXEL_CHECKSUM_EN
  logic                sum_clr, sum_add;
  logic [SAMPLE_W-1:0] csum;

  frame_checksum u_checksum (
    .clk      (clk_in),
    .rst      (rst_in),
    .clr      (sum_clr),
    .add_en   (sum_add),
    .add_data (rd_data_in),
    .sum      (csum)
  );
`endif

  // Guard mirrors the last valid pulse: the UART only drops ready a cycle later.
  assign permit = uart_ready_in && !guard_q;
  assign start  = (state_q == S_IDLE) && (frame_ready_in || pending_q) && transmit_active_in;

  always_comb begin
    pending_d = pending_q;
    overrun_d = 1'b0;
    if (start) begin
      pending_d = pending_q && frame_ready_in;
    end else if (frame_ready_in) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = rd_addr_out;
    valid_d = 1'b0;
    data_d  = uart_data_out;
    done_d  = 1'b0;
`ifdef TAXEL_CHECKSUM_EN
    sum_clr = 1'b0;
    sum_add = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
`ifdef TAXEL_CHECKSUM_EN
          sum_clr = 1'b1;
`endif
          // Header goes out straight from IDLE when the UART can take it.
          if (permit) begin
            valid_d = 1'b1;
            data_d  = HEADER_WORD;
            state_d = S_FETCH;
          end else begin
            state_d = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (permit) begin
          valid_d = 1'b1;
          data_d  = HEADER_WORD;
          state_d = S_FETCH;
        end
      end
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
`ifdef TAXEL_CHECKSUM_EN
        sum_add = 1'b1;
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (permit) begin
          valid_d = 1'b1;
          data_d  = sample_q;
          if (rd_addr_out == LAST_IDX) begin
`ifdef TAXEL_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = rd_addr_out + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
`ifdef TAXEL_CHECKSUM_EN
      S_CSUM: begin
        if (permit) begin
          valid_d = 1'b1;
          data_d  = csum;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      rd_addr_out    <= '0;
      uart_data_out  <= '0;
      uart_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      overrun_out    <= 1'b0;
      pending_q      <= 1'b0;
      guard_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_addr_out    <= idx_d;
      uart_data_out  <= data_d;
      uart_valid_out <= valid_d;
      busy_out       <= busy_d;
      frame_done_out <= done_d;
      overrun_out    <= overrun_d;
      pending_q      <= pending_d;
      guard_q        <= valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (state_q == S_CAPTURE) sample_q <= rd_data_in;
  end

endmodule

// File: tb/tb_taxel_uart_scheduler.sv
// Scoreboard bench for taxel_uart_scheduler with a 4-taxel buffer model and a
// uart_transmit model; expects the checksum word when TAXEL_CHECKSUM_EN is set.
module tb_taxel_uart_scheduler;

  localparam int NT   = 4;
  localparam int DONE = -1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_ready = 1'b0;
  logic        transmit_active = 1'b1;
  logic        hold_low = 1'b0;
  logic        model_ready = 1'b1;
  logic        uart_ready;
  logic [1:0]  rd_addr;
  logic [11:0] rd_data = 12'h0;
  logic [11:0] uart_data;
  logic        uart_valid, busy, frame_done, overrun;
  int          model_cnt = 0;

  int q[$];
  int errors = 0;
  int checks = 0;
  int overrun_cnt = 0;
  int valid_cnt = 0;

  taxel_uart_scheduler #(.NUM_TAXELS(NT), .HEADER_WORD(12'hA5A)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .frame_ready_in     (frame_ready),
    .transmit_active_in (transmit_active),
    .rd_addr_out        (rd_addr),
    .rd_data_in         (rd_data),
    .uart_ready_in      (uart_ready),
    .uart_data_out      (uart_data),
    .uart_valid_out     (uart_valid),
    .busy_out           (busy),
    .frame_done_out     (frame_done),
    .overrun_out        (overrun)
  );

  always #5 clk = ~clk;

  assign uart_ready = model_ready & ~hold_low;

  always @(posedge clk) rd_data <= 12'h100 + {10'd0, rd_addr};

  // UART model: ready falls the cycle after a valid and returns 10 cycles later.
  always @(posedge clk) begin
    if (uart_valid) begin
      model_ready <= 1'b0;
      model_cnt   <= 10;
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_ready <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (uart_valid) begin
        valid_cnt++;
        check("valid_while_ready", int'(uart_ready), 1);
        if (q.size() == 0) check("unexpected_word", int'(uart_data), DONE - 1);
        else               check("word", int'(uart_data), q.pop_front());
      end
      if (frame_done) begin
        if (q.size() == 0) check("unexpected_frame_done", DONE, DONE - 1);
        else               check("frame_done_order", DONE, q.pop_front());
      end
      if (overrun) overrun_cnt++;
    end
  end

  task automatic push_frame();
    q.push_back(12'hA5A);
    for (int i = 0; i < NT; i++) q.push_back(12'h100 + i);
`ifdef TAXEL_CHECKSUM_EN
    q.push_back(12'h406);
`endif
    q.push_back(DONE);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_timeout", int'(seen), 1);
  endtask

  task automatic wait_word(input int w, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (uart_valid && int'(uart_data) == w) seen = 1'b1;
    end
    check("word_timeout", int'(seen), 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_uart_data", int'(uart_data), 0);
    check("rst_uart_valid", int'(uart_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
  endtask

  initial begin
    int oc0, vc0;
    wait_cycles(3);
    check_reset_outputs();
    rst = 1'b0;
    wait_cycles(12);

    // Single frame with first-header latency of one cycle
    push_frame();
    @(negedge clk);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    check("header_latency_valid", int'(uart_valid), 1);
    check("header_latency_data", int'(uart_data), 12'hA5A);
    wait_done(300);
    check("single_no_overrun", overrun_cnt, 0);
    wait_cycles(15);

    // Pending frame plus one dropped request
    push_frame();
    push_frame();
    oc0 = overrun_cnt;
    pulse_frame();
    wait_cycles(5);
    pulse_frame();
    wait_cycles(5);
    check("pending_no_overrun", overrun_cnt - oc0, 0);
    wait_cycles(5);
    pulse_frame();
    wait_done(300);
    @(posedge clk);
    #1;
    check("pending_restart_busy", int'(busy), 1);
    wait_done(300);
    check("overrun_pulses", overrun_cnt - oc0, 1);
    wait_cycles(60);
    check("two_frames_only", q.size(), 0);

    // UART back-pressure held for 50 cycles during SEND
    push_frame();
    pulse_frame();
    wait_word(12'h100, 200);
    hold_low = 1'b1;
    vc0 = valid_cnt;
    wait_cycles(50);
    #1;
    check("no_valid_during_hold", valid_cnt - vc0, 0);
    hold_low = 1'b0;
    @(posedge clk);
    #1;
    check("resume_valid", int'(uart_valid), 1);
    check("resume_data", int'(uart_data), 12'h101);
    wait_done(300);
    wait_cycles(15);

    // Request while transmit inactive is held until enabled
    transmit_active = 1'b0;
    pulse_frame();
    wait_cycles(20);
    #1;
    check("inactive_not_busy", int'(busy), 0);
    push_frame();
    transmit_active = 1'b1;
    wait_done(300);
    wait_cycles(15);

    // Reset after the second sample aborts the frame cleanly
    q.push_back(12'hA5A);
    q.push_back(12'h100);
    q.push_back(12'h101);
    pulse_frame();
    wait_word(12'h101, 300);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    check("abort_queue_empty", q.size(), 0);
    wait_cycles(30);
    #1;
    check("abort_idle_busy", int'(busy), 0);
    push_frame();
    pulse_frame();
    wait_done(300);
    wait_cycles(20);
    check("final_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taxel_uart_scheduler.md
# taxel_uart_scheduler

Frame scheduler sitting between the taxel sample buffer and `uart_transmit`. On each completed sensor frame it reads `NUM_TAXELS` 12-bit samples from the buffer by address and hands them one at a time to the UART transmitter. Each frame is preceded by a sync header word and, optionally, followed by a checksum word. It owns the UART's `data_in`/`data_valid_in` handshake and holds one pending frame so that back-to-back frames are not lost.

## Interface
- `NUM_TAXELS`, default 64: samples per frame, ≥1.
- `HEADER_WORD`, default 12'hA5A: sync word sent first in every frame.
- `clk_in` input 1: system clock (100 MHz).
- `rst_in` input 1: reset. One clock; reset is synchronous and active-high.
- `frame_ready_in` input 1: one-cycle pulse; the buffer holds a complete new frame.
- `transmit_active_in` input 1: when low, no new frame starts; a frame already in flight completes.
- `rd_addr_out` output $clog2(NUM_TAXELS): sample buffer read address.
- `rd_data_in` input 12: sample at `rd_addr_out`, valid exactly one cycle after the address.
- `uart_ready_in` input 1: `ready_out` of `uart_transmit`.
- `uart_data_out` output 12: to `uart_transmit.data_in`.
- `uart_valid_out` output 1: to `uart_transmit.data_valid_in`; one-cycle pulse.
- `busy_out` output 1: high from the first cycle out of IDLE until return to IDLE.
- `frame_done_out` output 1: one-cycle pulse after the last word of a frame is issued.
- `overrun_out` output 1: one-cycle pulse when a frame request is dropped.

## Operation
- States: IDLE, HEADER, FETCH, CAPTURE, SEND, CSUM (only with macro), DONE.
- IDLE → HEADER: when (`frame_ready_in` or `pending`) and `transmit_active_in`. Clears `pending`, sets address to 0 and clears the checksum.
- HEADER: wait for send-permit. Then drive `uart_data_out`=`HEADER_WORD` with `uart_valid_out`=1 for one cycle → FETCH.
- FETCH: drive `rd_addr_out`=idx → CAPTURE.
- CAPTURE: register `rd_data_in` into the sample register and add it to the checksum → SEND.
- SEND: wait for send-permit, then pulse valid with the sample.
  - If idx = NUM_TAXELS−1: go to CSUM, or to DONE when the macro is absent.
  - Otherwise: idx+1 → FETCH.
- CSUM: wait for send-permit, pulse valid with the checksum → DONE.
- DONE: pulse `frame_done_out` → IDLE.
- Send-permit rule:
  - Permit = `uart_ready_in`=1 and guard=0.
  - Guard is set for the one cycle after any valid pulse. This masks the UART's one-cycle ready-drop latency.
  - Valid is never asserted while `uart_ready_in`=0.
- Pending frame:
  - `frame_ready_in` while not in IDLE, or while in IDLE with `transmit_active_in`=0, sets `pending`.
  - If `pending` is already set, the request is dropped and `overrun_out` pulses. `pending` stays set.
- Simultaneous events: `frame_ready_in` in the same cycle as IDLE→HEADER (driven by `pending`) sets `pending` again; no overrun.
- Checksum: 12-bit sum of all samples modulo 4096, excluding the header. Overflow wraps.
- Address wrap: idx counts 0..NUM_TAXELS−1 only and never exceeds that range.
- `transmit_active_in` falling mid-frame has no effect on the current frame.

## Timing
- All outputs are registered. Reset values:
  - state IDLE
  - `rd_addr_out`=0, `uart_data_out`=0
  - `uart_valid_out`=0, `busy_out`=0, `frame_done_out`=0, `overrun_out`=0
  - `pending`=0, guard=0, checksum=0
- `frame_ready_in` sampled at cycle 0 in IDLE with UART ready: header valid at cycle 1.
- Per-sample minimum: FETCH, CAPTURE, SEND = 3 cycles before the UART back-pressure wait.
- `rst_in` mid-frame: return to IDLE on the next edge. No further valid pulses, no `frame_done_out`, `pending` cleared.
- Frame length on the wire: NUM_TAXELS+1 words, or NUM_TAXELS+2 with the macro.

## Configuration
- `TAXEL_CHECKSUM_EN` defined: CSUM state and checksum accumulator are compiled in, and the checksum word is sent after the last sample.
- `TAXEL_CHECKSUM_EN` undefined: SEND on the last sample goes directly to DONE, and no accumulator logic exists.

## Structure
- Package `taxel_uart_pkg`:
  - state enum `sched_state_t`
  - `SAMPLE_W`=12
  - default `HEADER_WORD` constant
- Sub-module `frame_checksum`: 12-bit wrapping accumulator with `clr` and `add_en`; instantiated only under `TAXEL_CHECKSUM_EN`.
- Pending/overrun logic and FSM stay in the top module.

## Test plan
Bench uses NUM_TAXELS=4, buffer model returning 12'h100+addr with one-cycle read latency, and a `uart_transmit` model (ready drops one cycle after valid, returns after 10 cycles).
- Single frame, macro on → words 12'hA5A, 100, 101, 102, 103, 12'h406 in order; one `frame_done_out`.
- Single frame, macro off → 5 words, with `frame_done_out` after 12'h103.
- Second `frame_ready_in` mid-frame → the second frame starts immediately after DONE; `overrun_out` stays 0.
- Third `frame_ready_in` while busy with `pending` set → exactly one `overrun_out` pulse; only two frames sent in total.
- `uart_ready_in` held low 50 cycles during SEND → `uart_valid_out` stays 0 throughout; the sample goes out one cycle after ready returns.
- `rst_in` pulsed after the second sample → all outputs 0 next cycle; no further valids; a new `frame_ready_in` starts cleanly with the header.
